// File: rtl/access_sampler_if.sv
// ---------------------------------------------------------------------------
// access_sampler_if
// Push-side link between the access sampler and the profiler sample FIFO.
//   push : one-cycle push strobe (sampler -> FIFO)
//   data : {write bit, page number} of the sample (sampler -> FIFO)
//   full : FIFO cannot accept a push this cycle (FIFO -> sampler)
// The master modport is the sampler side; the slave modport is the FIFO side.
// ---------------------------------------------------------------------------
interface access_sampler_if #(
    parameter int DATA_W = 41
);
    logic              push;
    logic [DATA_W-1:0] data;
    logic              full;

    modport master (output push, output data, input full);
    modport slave  (input push, input data, output full);
endinterface

// File: rtl/access_sampler.sv
// ---------------------------------------------------------------------------
// access_sampler
// Feeds the profiler sample FIFO from the CXL request monitor's raw access
// stream. That stream has no backpressure. The sampler keeps 1 of every
// (rate_i+1) accesses and converts each kept access to a page number. It drops
// back-to-back repeats of the last pushed page, then pushes the survivors.
// Three saturating counters report what happened to each kept access.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   flush_i           synchronous clear of pipeline, sample counter, dedup, stats
//   en_i              sampling enable (in-flight sample still completes when low)
//   rate_i            keep 1 of rate_i+1 accesses
//   acc_valid_i       access observed this cycle
//   acc_addr_i        byte address of the access
//   acc_write_i       1 = write, 0 = read
//   fifo              push/data/full link to the sample FIFO (master side)
//   sampled_cnt_o     samples pushed
//   dup_cnt_o         kept accesses dropped as a repeat of the last pushed page
//   drop_cnt_o        kept accesses dropped because the FIFO was full
// ---------------------------------------------------------------------------
module access_sampler #(
    parameter int ADDR_WIDTH = 52,
    parameter int PAGE_SHIFT = 12,
    parameter int RATE_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  en_i,
    input  logic [RATE_WIDTH-1:0] rate_i,
    input  logic                  acc_valid_i,
    input  logic [ADDR_WIDTH-1:0] acc_addr_i,
    input  logic                  acc_write_i,
    access_sampler_if.master      fifo,
    output logic [CNT_WIDTH-1:0]  sampled_cnt_o,
    output logic [CNT_WIDTH-1:0]  dup_cnt_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam int PAGE_W = ADDR_WIDTH - PAGE_SHIFT;

    localparam logic [RATE_WIDTH-1:0] RATE_ONE = {{(RATE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    // Stage-1 sample register, sampling counter and dedup state
    logic                  r_s1_valid;
    logic [PAGE_W-1:0]     r_s1_page;
    logic                  r_s1_wr;
    logic [RATE_WIDTH-1:0] r_samp_cnt;
    logic                  r_last_valid;
    logic [PAGE_W-1:0]     r_last_page;
    logic [CNT_WIDTH-1:0]  r_sampled;
    logic [CNT_WIDTH-1:0]  r_dup;
    logic [CNT_WIDTH-1:0]  r_drop;

    logic              w_take;
    logic              w_hit;
    logic [PAGE_W-1:0] w_page;
    logic              w_dup;
    logic              w_push;
    logic              w_full_drop;
    logic              w_unused_offset;

    // ---------------- stage 0: decimation ----------------
    assign w_page          = acc_addr_i[ADDR_WIDTH-1:PAGE_SHIFT];
    assign w_unused_offset = ^acc_addr_i[PAGE_SHIFT-1:0];
    assign w_take          = acc_valid_i & en_i & ~flush_i;
    // >= rather than == so that lowering rate_i mid-run fires on the next access
    // instead of waiting for the counter to wrap.
    assign w_hit           = (r_samp_cnt >= rate_i);

    // ---------------- stage 1: dedup and push ----------------
    // The write bit does not take part in dedup: only the page number is compared.
    assign w_dup       = r_last_valid & (r_s1_page == r_last_page);
    // flush_i also blocks the push, so no sample reaches a FIFO that is being flushed.
    assign w_push      = r_s1_valid & ~w_dup & ~fifo.full & ~flush_i;
    assign w_full_drop = r_s1_valid & ~w_dup & fifo.full;

    assign fifo.push     = w_push;
    assign fifo.data     = {r_s1_wr, r_s1_page};
    assign sampled_cnt_o = r_sampled;
    assign dup_cnt_o     = r_dup;
    assign drop_cnt_o    = r_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid   <= 1'b0;
            r_s1_page    <= '0;
            r_s1_wr      <= 1'b0;
            r_samp_cnt   <= '0;
            r_last_valid <= 1'b0;
            r_last_page  <= '0;
            r_sampled    <= '0;
            r_dup        <= '0;
            r_drop       <= '0;
        end else if (flush_i) begin
            // The arriving access is discarded. last_page may stay stale because
            // last_valid is cleared.
            r_s1_valid   <= 1'b0;
            r_samp_cnt   <= '0;
            r_last_valid <= 1'b0;
            r_sampled    <= '0;
            r_dup        <= '0;
            r_drop       <= '0;
        end else begin
            if (w_take) begin
                r_samp_cnt <= w_hit ? '0 : r_samp_cnt + RATE_ONE;
                r_s1_valid <= w_hit;
                r_s1_page  <= w_page;
                r_s1_wr    <= acc_write_i;
            end else begin
                r_s1_valid <= 1'b0;
            end

            // Only a real push moves the dedup reference. Drops leave it unchanged.
            if (w_push) begin
                r_last_valid <= 1'b1;
                r_last_page  <= r_s1_page;
            end

            // At most one of these fires per stage-1 sample. A dup takes priority
            // over a full drop.
            if (w_push && r_sampled != '1)
                r_sampled <= r_sampled + CNT_ONE;
            if (r_s1_valid && w_dup && r_dup != '1)
                r_dup <= r_dup + CNT_ONE;
            if (w_full_drop && r_drop != '1)
                r_drop <= r_drop + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_access_sampler.sv
// Bench for access_sampler: directed scenarios followed by a randomized run.
// Every cycle is compared against a transaction-level model of the sampler.
module tb_access_sampler;

    localparam int AW = 52;
    localparam int PS = 12;
    localparam int RW = 16;
    localparam int CW = 4;            // narrow counters so saturation is reachable
    localparam int DW = AW - PS + 1;
    localparam longint CMAX = (64'd1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          flush_i;
    logic          en_i;
    logic [RW-1:0] rate_i;
    logic          acc_valid_i;
    logic [AW-1:0] acc_addr_i;
    logic          acc_write_i;
    logic [CW-1:0] sampled_cnt_o, dup_cnt_o, drop_cnt_o;

    access_sampler_if #(.DATA_W(DW)) fif ();

    access_sampler #(
        .ADDR_WIDTH(AW), .PAGE_SHIFT(PS), .RATE_WIDTH(RW), .CNT_WIDTH(CW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .en_i         (en_i),
        .rate_i       (rate_i),
        .acc_valid_i  (acc_valid_i),
        .acc_addr_i   (acc_addr_i),
        .acc_write_i  (acc_write_i),
        .fifo         (fif),
        .sampled_cnt_o(sampled_cnt_o),
        .dup_cnt_o    (dup_cnt_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each access bumps "since". An access is kept once since >= rate, and keeping it
    // restarts the count. A kept access is pushed on the following cycle unless it
    // repeats the last pushed page, the FIFO is full, or a flush is in progress.
    bit     m_pend;
    longint m_pend_page;
    bit     m_pend_wr;
    longint m_since;
    bit     m_last_v;
    longint m_last_page;
    longint m_sampled, m_dup, m_drop;
    int     pushes_seen;

    function automatic longint sat_inc(input longint v);
        return (v == CMAX) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_pend_page = 0; m_pend_wr = 0; m_since = 0;
        m_last_v = 0; m_last_page = 0; m_sampled = 0; m_dup = 0; m_drop = 0;
    endtask

    // One clock cycle. Entered at posedge+1, returns at the next posedge+1.
    task automatic cyc(input bit v, input longint page, input bit wr,
                       input bit full, input bit fl);
        bit     is_dup, exp_push, kept;
        longint off;
        off = longint'($urandom_range(0, (1 << PS) - 1));
        acc_valid_i = v;
        acc_addr_i  = AW'((page << PS) | off);
        acc_write_i = wr;
        fif.full    = full;
        flush_i     = fl;
        #3;
        is_dup   = m_pend && m_last_v && (m_pend_page == m_last_page);
        exp_push = m_pend && !is_dup && !full && !fl;
        check("push", 64'(fif.push), 64'(exp_push));
        if (m_pend)
            check("data", 64'(fif.data), {m_pend_wr, m_pend_page[AW-PS-1:0]});
        if (fif.push) pushes_seen++;
        @(posedge clk);
        if (fl) begin
            m_pend = 0; m_since = 0; m_last_v = 0;
            m_sampled = 0; m_dup = 0; m_drop = 0;
        end else begin
            if (exp_push) begin
                m_sampled = sat_inc(m_sampled);
                m_last_v = 1; m_last_page = m_pend_page;
            end else if (m_pend && is_dup) m_dup = sat_inc(m_dup);
            else if (m_pend) m_drop = sat_inc(m_drop);
            if (v && en_i) begin
                kept = (m_since >= longint'(rate_i));
                m_since = kept ? 0 : m_since + 1;
                m_pend = kept; m_pend_page = page; m_pend_wr = wr;
            end else m_pend = 0;
        end
        #1;
        check("sampled_cnt", 64'(sampled_cnt_o), 64'(m_sampled));
        check("dup_cnt",     64'(dup_cnt_o),     64'(m_dup));
        check("drop_cnt",    64'(drop_cnt_o),    64'(m_drop));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push"},    64'(fif.push),      64'd0);
        check({tag, "_data"},    64'(fif.data),      64'd0);
        check({tag, "_sampled"}, 64'(sampled_cnt_o), 64'd0);
        check({tag, "_dup"},     64'(dup_cnt_o),     64'd0);
        check({tag, "_drop"},    64'(drop_cnt_o),    64'd0);
    endtask

    initial begin
        rst_ni = 0; flush_i = 0; en_i = 1; rate_i = 0;
        acc_valid_i = 0; acc_addr_i = '0; acc_write_i = 0; fif.full = 0;
        model_reset();
        pushes_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_ni = 1;

        // 1: keep everything, pages 1,2,3 pushed one cycle later
        rate_i = 0;
        cyc(1, 1, 0, 0, 0); cyc(1, 2, 1, 0, 0); cyc(1, 3, 0, 0, 0); idle(1);
        check("t1_sampled", 64'(sampled_cnt_o), 64'd3);

        // 2: rate 3 over 12 distinct pages -> accesses 4, 8, 12
        cyc(0, 0, 0, 0, 1);
        rate_i = 3; pushes_seen = 0;
        for (int i = 0; i < 12; i++) cyc(1, 64'(16 + i), 0, 0, 0);
        idle(1);
        check("t2_pushes",  64'(pushes_seen),   64'd3);
        check("t2_sampled", 64'(sampled_cnt_o), 64'd3);
        check("t2_dup",     64'(dup_cnt_o),     64'd0);

        // 3: 0x5000, 0x5FF8, 0x6000, 0x5000 -> pages 5,6,5 and one dup
        cyc(0, 0, 0, 0, 1);
        rate_i = 0;
        cyc(1, 5, 0, 0, 0); cyc(1, 5, 1, 0, 0); cyc(1, 6, 0, 0, 0); cyc(1, 5, 0, 0, 0);
        idle(1);
        check("t3_sampled", 64'(sampled_cnt_o), 64'd3);
        check("t3_dup",     64'(dup_cnt_o),     64'd1);

        // 4: full drops pages 7,8; page 8 then pushes (last page still 5)
        cyc(1, 7, 0, 1, 0); cyc(1, 8, 0, 1, 0); cyc(0, 0, 0, 1, 0);
        check("t4_drop", 64'(drop_cnt_o), 64'd2);
        pushes_seen = 0;
        cyc(1, 8, 0, 0, 0); idle(1);
        check("t4_push8", 64'(pushes_seen), 64'd1);

        // 5: flush while s1 holds a hit, then rate 2 pushes on the 3rd access
        cyc(1, 9, 0, 0, 0);
        pushes_seen = 0;
        cyc(0, 0, 0, 0, 1);
        check("t5_flush_push", 64'(pushes_seen), 64'd0);
        check("t5_sampled",    64'(sampled_cnt_o), 64'd0);
        rate_i = 2;
        cyc(1, 10, 0, 0, 0); cyc(1, 11, 0, 0, 0); cyc(1, 12, 0, 0, 0); idle(1);
        check("t5_pushes", 64'(pushes_seen), 64'd1);

        // 6: long full stall saturates drop_cnt, then async reset mid-stream
        rate_i = 0;
        for (int i = 0; i < 20; i++) cyc(1, 64'(100 + i), 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check("t6_drop_sat", 64'(drop_cnt_o), CMAX);
        cyc(1, 200, 1, 0, 0);
        acc_valid_i = 1; acc_addr_i = AW'(64'd201 << PS);
        #2 rst_ni = 0;
        #1 check_all_zero("async_rst");
        @(posedge clk); #1;
        rst_ni = 1; acc_valid_i = 0;
        model_reset();

        // randomized run: small page pool to exercise dedup, random full/enable/rate
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) rate_i = RW'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) en_i = ~en_i;
            cyc($urandom_range(0, 3) != 0, longint'($urandom_range(0, 5)), 1'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
